sync_filter_edge: RTL and testbench
===================================

SYNC_FILTER_EDGE -- requirements
Module: sync_filter_edge

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2; synchronizer flop stages per channel, legal values 2 and above.
REQ-002 SHALL have parameter BUS_WIDTH, default 4; number of independent single-bit channels, legal values 1 and above.
REQ-003 SHALL have parameter FILT_CNT, default 3; consecutive stable cycles required before a filtered channel output changes, legal values 1 and above.
REQ-004 Port: CLK  input  1  single clock; all state on its rising edge.
REQ-005 Port: RST  input  1  reset, synchronous and active-high.
REQ-006 Port: ASYNC  input  BUS_WIDTH  asynchronous level inputs, one per channel.
REQ-007 Port: FILT_EN  input  BUS_WIDTH  per-channel mode select; 1 = glitch-filtered, 0 = plain synchronizer; synchronous to CLK.
REQ-008 Port: SYNC  output  BUS_WIDTH  registered synchronized and optionally filtered level.
REQ-009 Port: RISE  output  BUS_WIDTH  one-cycle pulse on a SYNC 0->1 transition.
REQ-010 Port: FALL  output  BUS_WIDTH  one-cycle pulse on a SYNC 1->0 transition.
REQ-011 Port: CHG  output  1  one-cycle pulse when any bit of RISE or FALL is set.

Function
REQ-012 Each channel SHALL pass ASYNC[i] through a NUM_STAGES flop shift chain; the last stage is "raw[i]"; no combinational logic SHALL sit between chain stages.
REQ-013 Define edge k as the first CLK edge that samples a new ASYNC[i] level.
REQ-014 With FILT_EN[i]=0, SYNC[i] SHALL load raw[i] every cycle, so SYNC[i] updates on edge k+NUM_STAGES.
REQ-015 With FILT_EN[i]=1, a per-channel counter cnt[i] of width clog2(FILT_CNT+1) SHALL behave as follows: cnt[i] resets to 0 whenever raw[i]==SYNC[i]; it increments whenever raw[i]!=SYNC[i]; when cnt[i]==FILT_CNT-1 and raw[i]!=SYNC[i], SYNC[i] loads raw[i] and cnt[i] returns to 0.
REQ-016 Under REQ-015, a stable filtered change SHALL appear on SYNC[i] on edge k+NUM_STAGES+FILT_CNT-1.
REQ-017 Under REQ-015, a raw[i] excursion shorter than FILT_CNT cycles SHALL produce no change on SYNC[i].
REQ-018 The counter SHALL saturate only through REQ-015 and SHALL never wrap.
REQ-019 When FILT_EN[i] is 0, cnt[i] SHALL be held at 0.
REQ-020 When FILT_EN[i] goes 1->0 with a pending mismatch, SYNC[i] SHALL take raw[i] on the next edge.
REQ-021 When FILT_EN[i] goes 0->1, counting SHALL start from 0.
REQ-022 RISE[i] and FALL[i] SHALL be registered and asserted for exactly the single cycle in which SYNC[i] first shows its new value.
REQ-023 RISE[i] and FALL[i] SHALL never be asserted together.
REQ-024 CHG SHALL be registered in the same cycle as the RISE and FALL pulses that cause it.
REQ-025 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous pulses.

Reset
REQ-026 On RST=1 at a CLK edge, all chain stages, SYNC, cnt, RISE, FALL and CHG SHALL become 0.
REQ-027 If ASYNC is 1 when reset is released, RISE SHALL pulse when SYNC reaches 1; this is a legitimate edge.
REQ-028 Reset asserted mid-filter SHALL discard the partial count.

Configuration
REQ-029 Macro SYNC_FILTER_EDGE_DET_EN defined: RISE, FALL and CHG logic SHALL be present as specified in REQ-022 to REQ-024.
REQ-030 Macro SYNC_FILTER_EDGE_DET_EN undefined: the RISE, FALL and CHG ports SHALL remain and be tied to constant 0, with no edge flops synthesized; SYNC behaviour SHALL be unchanged.

Structure
REQ-031 Shared package sync_pkg SHALL hold the default constants for NUM_STAGES, BUS_WIDTH and FILT_CNT, plus the counter-width function.
REQ-032 A sub-module sync_filter_chan SHALL implement one channel (chain, filter, edge flops); the top SHALL generate BUS_WIDTH instances of it and form CHG as the OR of their pulses.
REQ-033 Illegal parameter values (NUM_STAGES<2, FILT_CNT<1) SHALL be rejected at elaboration.

Verification (NUM_STAGES=2, BUS_WIDTH=4, FILT_CNT=3, macro defined)
REQ-034 Reset then release with ASYNC=4'b0000 -> SYNC=0, and RISE, FALL and CHG remain 0 for 20 cycles.
REQ-035 FILT_EN=0, ASYNC[0] 0->1 before edge k -> SYNC[0]=1 after edge k+2; RISE[0]=1 and CHG=1 for exactly that one cycle.
REQ-036 FILT_EN=4'b1111, ASYNC[1] held high for 2 cycles then low -> SYNC[1] stays 0 and no pulses occur; held high for 5 cycles -> SYNC[1]=1 after edge k+4, with a RISE[1] pulse.
REQ-037 ASYNC 4'b1111->4'b0000 with FILT_EN=4'b0101 -> FALL[0] and FALL[2] pulse at k+4, FALL[1] and FALL[3] pulse at k+2, and CHG pulses in both cycles.
REQ-038 FILT_EN[2] 1->0 while cnt[2]=1 with mismatch -> SYNC[2] updates on the next edge; RST asserted while cnt=2 -> all outputs 0 and no pulse after release if ASYNC=0.
REQ-039 Macro undefined with stimulus of REQ-035 -> SYNC identical to REQ-035, and RISE, FALL and CHG constantly 0.

Source files
------------

// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
//   Shared defaults and helpers for the sync_filter_edge block.
//
//   Contents:
//     DEF_NUM_STAGES  default synchronizer depth per channel
//     DEF_BUS_WIDTH   default number of independent channels
//     DEF_FILT_CNT    default number of stable cycles before a filtered
//                     channel is allowed to change
//     cnt_width()     width of the per-channel stability counter
// -----------------------------------------------------------------------------
package sync_pkg;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_BUS_WIDTH  = 4;
    localparam int DEF_FILT_CNT   = 3;

    // The counter must hold values 0 .. FILT_CNT, so clog2(FILT_CNT+1) bits.
    // Illegal FILT_CNT values are trapped elsewhere; return 1 so the width
    // stays positive long enough for that check to report.
    function automatic int cnt_width(input int filt_cnt);
        return (filt_cnt < 1) ? 1 : $clog2(filt_cnt + 1);
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// -----------------------------------------------------------------------------
// sync_filter_chan
//   One channel of the synchronizer/filter: a NUM_STAGES flop chain, an
//   optional glitch filter and, when SYNC_FILTER_EDGE_DET_EN is defined,
//   registered rise/fall pulse flops.
//
//   Configuration macro: SYNC_FILTER_EDGE_DET_EN
//     defined   -> rise/fall are registered edge pulses, pulse_next exists
//     undefined -> rise/fall tied to 0, no edge flops, no pulse_next port
//
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     level       asynchronous level input
//     filt_en     1 = glitch-filtered, 0 = plain synchronizer
//     sync        registered output level
//     rise        one-cycle pulse in the first cycle sync shows 1
//     fall        one-cycle pulse in the first cycle sync shows 0
//     pulse_next  (macro only) sync is about to change on the next edge
// -----------------------------------------------------------------------------
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int FILT_CNT   = DEF_FILT_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic filt_en,
    output logic sync,
    output logic rise,
`ifdef SYNC_FILTER_EDGE_DET_EN
    output logic fall,
    output logic pulse_next
`else
    output logic fall
`endif
);

    localparam int              CW   = cnt_width(FILT_CNT);
    localparam logic [CW-1:0]   LAST = CW'(FILT_CNT - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("sync_filter_chan: NUM_STAGES must be 2 or more");
    end
    if (FILT_CNT < 1) begin : g_bad_filt
        $error("sync_filter_chan: FILT_CNT must be 1 or more");
    end

    logic [NUM_STAGES-1:0] chain;
    logic                  raw;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_d;
    logic                  sync_d;

    // Pure shift chain: nothing may sit between stages, otherwise the
    // metastability settling time of each stage is eaten by logic delay.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    // NOTE: the chain is reset on purpose -- it is a handful of flops, not a
    // memory, and a clean 0 after reset is what makes the first edge defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], level};
        end
    end

    assign raw = chain[NUM_STAGES-1];

    // Filter: count consecutive cycles in which raw disagrees with sync; the
    // FILT_CNT-th disagreeing cycle commits the new level. Any agreement, or
    // leaving filtered mode, drops the partial count. The counter tops out at
    // FILT_CNT-1 and never wraps.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sync_d = sync;
        cnt_d  = '0;
        if (!filt_en) begin
            sync_d = raw;
        end else if (raw != sync) begin
            if (cnt == LAST) begin
                sync_d = raw;
            end else begin
                cnt_d = cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= sync_d;
            cnt  <= cnt_d;
        end
    end

`ifdef SYNC_FILTER_EDGE_DET_EN
    // Edge flops load alongside sync, so a pulse lines up with the first
    // cycle that sync shows its new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= sync_d & ~sync;
            fall <= ~sync_d & sync;
        end
    end

    assign pulse_next = sync_d ^ sync;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_edge.sv
// -----------------------------------------------------------------------------
// sync_filter_edge
//   Multi-channel level synchronizer with optional per-channel glitch filter
//   and edge detection. Each bit is an independent sync_filter_chan.
//
//   Configuration macro: SYNC_FILTER_EDGE_DET_EN
//     defined   -> RISE/FALL/CHG are registered one-cycle pulses
//     undefined -> RISE/FALL/CHG tied to 0; SYNC behaviour unchanged
//
//   Parameters:
//     NUM_STAGES  synchronizer flops per channel (>= 2)
//     BUS_WIDTH   number of channels (>= 1)
//     FILT_CNT    stable cycles needed before a filtered output changes (>= 1)
//
//   Ports:
//     CLK      rising-edge clock
//     RST      synchronous active-high reset
//     ASYNC    asynchronous level inputs, one per channel
//     FILT_EN  per-channel mode: 1 = filtered, 0 = plain synchronizer
//     SYNC     registered synchronized (optionally filtered) levels
//     RISE     per-channel pulse on SYNC 0->1
//     FALL     per-channel pulse on SYNC 1->0
//     CHG      pulse when any RISE or FALL bit is set
// -----------------------------------------------------------------------------
module sync_filter_edge
    import sync_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int FILT_CNT   = DEF_FILT_CNT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    input  logic [BUS_WIDTH-1:0] FILT_EN,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL,
    output logic                 CHG
);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("sync_filter_edge: NUM_STAGES must be 2 or more");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("sync_filter_edge: BUS_WIDTH must be 1 or more");
    end
    if (FILT_CNT < 1) begin : g_bad_filt
        $error("sync_filter_edge: FILT_CNT must be 1 or more");
    end

`ifdef SYNC_FILTER_EDGE_DET_EN
    logic [BUS_WIDTH-1:0] pulse_next;
`endif

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .NUM_STAGES (NUM_STAGES),
            .FILT_CNT   (FILT_CNT)
        ) u_chan (
            .clk        (CLK),
            .rst        (RST),
            .level      (ASYNC[i]),
            .filt_en    (FILT_EN[i]),
            .sync       (SYNC[i]),
            .rise       (RISE[i]),
`ifdef SYNC_FILTER_EDGE_DET_EN
            .fall       (FALL[i]),
            .pulse_next (pulse_next[i])
`else
            .fall       (FALL[i])
`endif
        );
    end

`ifdef SYNC_FILTER_EDGE_DET_EN
    // CHG is built from the channels' next-edge indications and registered
    // here, so it is a true flop output aligned with the RISE/FALL pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CHG <= 1'b0;
        end else begin
            CHG <= |pulse_next;
        end
    end
`else
    assign CHG = 1'b0;
`endif

endmodule

// File: tb/tb_sync_filter_edge.sv
// -----------------------------------------------------------------------------
// tb_sync_filter_edge
//   Scoreboard bench for sync_filter_edge (NUM_STAGES=2, BUS_WIDTH=4,
//   FILT_CNT=3). The stimulus task records every edge's inputs, derives the
//   expected outputs from the input history and pushes them into a queue; a
//   monitor pops one entry per clock and compares. Expected edge pulses follow
//   SYNC_FILTER_EDGE_DET_EN exactly as the design does.
// -----------------------------------------------------------------------------
module tb_sync_filter_edge;

    localparam int NS   = 2;
    localparam int BW   = 4;
    localparam int FC   = 3;
    localparam int MAXC = 4000;

`ifdef SYNC_FILTER_EDGE_DET_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [BW-1:0] sync;
        logic [BW-1:0] rise;
        logic [BW-1:0] fall;
        logic          chg;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [BW-1:0] ASYNC = '0;
    logic [BW-1:0] FILT_EN = '0;
    logic [BW-1:0] SYNC;
    logic [BW-1:0] RISE;
    logic [BW-1:0] FALL;
    logic          CHG;

    sync_filter_edge #(
        .NUM_STAGES (NS),
        .BUS_WIDTH  (BW),
        .FILT_CNT   (FC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ASYNC   (ASYNC),
        .FILT_EN (FILT_EN),
        .SYNC    (SYNC),
        .RISE    (RISE),
        .FALL    (FALL),
        .CHG     (CHG)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int dut_pulses = 0;
    int mdl_pulses = 0;
    int cyc = 0;

    exp_t sb_q[$];

    // Input history, indexed by clock edge number.
    logic [BW-1:0] in_h  [MAXC];
    logic [BW-1:0] en_h  [MAXC];
    logic          rst_h [MAXC];

    // Model state: current expected SYNC and the edge of its last change.
    logic [BW-1:0] m_sync = '0;
    int            last_chg [BW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // The level the channel logic sees at edge t: the input sampled NS edges
    // earlier, unless a reset inside that window cleared it.
    function automatic logic raw_at(input int i, input int t);
        if (t - NS < 0) return 1'b0;
        for (int e = t - NS; e < t; e++) begin
            if (rst_h[e]) return 1'b0;
        end
        return in_h[t - NS][i];
    endfunction

    // Expected outputs just after edge t. A filtered channel changes once the
    // seen level has disagreed with SYNC on FC consecutive filtered edges
    // since SYNC last changed; an unfiltered channel follows the seen level.
    task automatic model_edge(input int t, output exp_t e);
        logic [BW-1:0] nxt;
        e = '0;
        nxt = m_sync;
        for (int i = 0; i < BW; i++) begin
            if (rst_h[t]) begin
                nxt[i] = 1'b0;
                last_chg[i] = t;
            end else if (!en_h[t][i]) begin
                nxt[i] = raw_at(i, t);
            end else begin
                int run = 0;
                for (int idx = t; idx > last_chg[i] && idx >= 0 && run < FC; idx--) begin
                    if (rst_h[idx] || !en_h[idx][i] || raw_at(i, idx) == m_sync[i]) break;
                    run++;
                end
                if (run == FC) nxt[i] = ~m_sync[i];
            end
            if (!rst_h[t] && nxt[i] != m_sync[i]) last_chg[i] = t;
        end
        if (!rst_h[t] && EDGE_EN) begin
            e.rise = nxt & ~m_sync;
            e.fall = ~nxt & m_sync;
            e.chg  = |(e.rise | e.fall);
        end
        e.sync = nxt;
        m_sync = nxt;
        mdl_pulses += $countones(e.rise) + $countones(e.fall);
    endtask

    task automatic step(input logic r, input logic [BW-1:0] a, input logic [BW-1:0] en);
        exp_t e;
        @(negedge CLK);
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow cycle=%0d got=%0d expected<%0d", cyc, cyc, MAXC);
            $fatal(1, "history overflow");
        end
        RST = r;
        ASYNC = a;
        FILT_EN = en;
        rst_h[cyc] = r;
        in_h[cyc]  = a;
        en_h[cyc]  = en;
        model_edge(cyc, e);
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic hold(input int n, input logic r, input logic [BW-1:0] a, input logic [BW-1:0] en);
        for (int j = 0; j < n; j++) step(r, a, en);
    endtask

    // Monitor: one expected entry per edge, compared 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sync", 64'(SYNC), 64'(e.sync));
                check("rise_fall_chg", 64'({RISE, FALL, CHG}), 64'({e.rise, e.fall, e.chg}));
                dut_pulses += $countones(RISE) + $countones(FALL);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] a;
        logic [BW-1:0] en;
        logic          r;
        for (int i = 0; i < BW; i++) last_chg[i] = -1;

        // Reset, then 20 quiet cycles: no pulses.
        hold(3, 1'b1, 4'b0000, 4'b0000);
        hold(20, 1'b0, 4'b0000, 4'b0000);

        // Plain synchronizer rise and fall on channel 0.
        hold(6, 1'b0, 4'b0001, 4'b0000);
        hold(6, 1'b0, 4'b0000, 4'b0000);

        // Filtered: 2-cycle glitch is suppressed, 5-cycle level passes.
        hold(2, 1'b0, 4'b0010, 4'b1111);
        hold(8, 1'b0, 4'b0000, 4'b1111);
        hold(5, 1'b0, 4'b0010, 4'b1111);
        hold(8, 1'b0, 4'b0000, 4'b1111);

        // Mixed modes: plain channels fall 2 cycles before filtered ones.
        hold(8, 1'b0, 4'b1111, 4'b0101);
        hold(8, 1'b0, 4'b0000, 4'b0101);

        // Leave filtered mode mid-count on channel 2.
        hold(3, 1'b0, 4'b0100, 4'b1111);
        hold(5, 1'b0, 4'b0100, 4'b1011);
        hold(8, 1'b0, 4'b0000, 4'b1111);

        // Reset mid-filter discards the partial count.
        hold(4, 1'b0, 4'b0001, 4'b1111);
        hold(2, 1'b1, 4'b0000, 4'b1111);
        hold(10, 1'b0, 4'b0000, 4'b1111);

        // Reset release with inputs high is a legitimate rising edge.
        hold(2, 1'b1, 4'b1111, 4'b0011);
        hold(8, 1'b0, 4'b1111, 4'b0011);

        // Randomized traffic: sparse flips, occasional mode changes and resets.
        a  = 4'b1111;
        en = 4'b0011;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) a ^= BW'($urandom) & BW'($urandom);
            if ($urandom_range(0, 59) == 0) en = BW'($urandom);
            r = ($urandom_range(0, 249) == 0);
            step(r, a, en);
        end
        hold(10, 1'b0, a, en);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("pulse_total", 64'(dut_pulses), 64'(mdl_pulses));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
